// File: rtl/sram_port_arbiter.sv
// Two-requester arbiter for one synchronous single-port SRAM.
// The data port has fixed priority; a saturating counter forces a fetch grant after STARVE_LIMIT denials.
module sram_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 3
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,

  output logic        sram_en,
  output logic [3:0]  sram_we,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata
);

  localparam logic [CNT_W-1:0] LP_LIMIT = CNT_W'(STARVE_LIMIT);

  typedef struct packed {
    logic inst;
    logic data;
  } owner_t;

  logic [CNT_W-1:0] r_starve_cnt;
  owner_t           r_resp_owner;
  logic             r_resp_load;

  logic             w_inst_force;
  logic             w_grant_data;
  logic             w_grant_inst;
  logic [CNT_W-1:0] w_starve_nxt;

  // Grants are masked while in reset so no request can be accepted.
  always_comb begin
    w_inst_force = (r_starve_cnt == LP_LIMIT);
    w_grant_data = ~reset & data_req & ~(inst_req & w_inst_force);
    w_grant_inst = ~reset & inst_req & ~w_grant_data;
  end

  assign inst_addr_ok = w_grant_inst;
  assign data_addr_ok = w_grant_data;

  always_comb begin
    sram_en    = 1'b0;
    sram_we    = '0;
    sram_addr  = '0;
    sram_wdata = '0;
    if (w_grant_data) begin
      sram_en    = 1'b1;
      sram_we    = data_wr ? data_wstrb : 4'b0000;
      sram_addr  = data_addr;
      sram_wdata = data_wdata;
    end else if (w_grant_inst) begin
      sram_en    = 1'b1;
      sram_addr  = inst_addr;
    end
  end

  always_comb begin
    w_starve_nxt = '0;
    if (inst_req && !w_grant_inst) begin
      w_starve_nxt = (r_starve_cnt == LP_LIMIT) ? r_starve_cnt : r_starve_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_starve_cnt <= '0;
      r_resp_owner <= '0;
      r_resp_load  <= 1'b0;
    end else begin
      r_starve_cnt      <= w_starve_nxt;
      r_resp_owner.inst <= w_grant_inst;
      r_resp_owner.data <= w_grant_data;
      r_resp_load       <= w_grant_data & ~data_wr;
    end
  end

  // Reset in the cycle after a grant also suppresses the response already in flight.
  always_comb begin
    inst_data_ok = r_resp_owner.inst & ~reset;
    data_data_ok = r_resp_owner.data & ~reset;
    inst_rdata   = inst_data_ok ? sram_rdata : '0;
    data_rdata   = (data_data_ok && r_resp_load) ? sram_rdata : '0;
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a behavioural byte-writable SRAM
// that returns read data one cycle after sram_en.
module tb_sram_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        sram_en;
  logic [3:0]  sram_we;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  logic [31:0] mem [logic [31:0]];

  sram_port_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
    .clk          (clk),
    .reset        (reset),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_wstrb   (data_wstrb),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .sram_en      (sram_en),
    .sram_we      (sram_we),
    .sram_addr    (sram_addr),
    .sram_wdata   (sram_wdata),
    .sram_rdata   (sram_rdata)
  );

  always #5 clk = ~clk;

  // Read returns the pre-write contents; byte strobes merge into the stored word.
  always @(posedge clk) begin
    logic [31:0] w;
    if (sram_en) begin
      w = mem.exists(sram_addr) ? mem[sram_addr] : 32'h0;
      sram_rdata <= w;
      for (int b = 0; b < 4; b++)
        if (sram_we[b]) w[b*8 +: 8] = sram_wdata[b*8 +: 8];
      mem[sram_addr] = w;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #3;
  endtask

  logic pat [10];

  initial begin
    pat = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    mem[32'h1c000000] = 32'h02800c21;
    mem[32'h1c000100] = 32'hdeadbeef;
    mem[32'h1c000200] = 32'haaaaaaaa;
    for (int i = 0; i < 8; i++) mem[32'h1c001000 + 32'(4*i)] = 32'h5a000000 + 32'(i * 17);

    reset = 1'b1; inst_req = 1'b1; inst_addr = 32'h1c000000;
    data_req = 1'b1; data_wr = 1'b0; data_wstrb = 4'h0; data_addr = 32'h1c000100; data_wdata = '0;
    tick; tick;
    settle;
    chk("rst_inst_addr_ok", 32'(inst_addr_ok), 32'd0);
    chk("rst_data_addr_ok", 32'(data_addr_ok), 32'd0);
    chk("rst_sram_en",      32'(sram_en),      32'd0);
    chk("rst_cnt",          32'(dut.r_starve_cnt), 32'd0);

    tick;
    reset = 1'b0; inst_req = 1'b0; data_req = 1'b0;
    tick;
    settle;
    chk("post_rst_inst_data_ok", 32'(inst_data_ok), 32'd0);
    chk("post_rst_data_data_ok", 32'(data_data_ok), 32'd0);
    chk("post_rst_inst_rdata",   inst_rdata, 32'h0);
    chk("post_rst_data_rdata",   data_rdata, 32'h0);

    // fetch alone
    tick;
    inst_req = 1'b1; inst_addr = 32'h1c000000;
    settle;
    chk("f_inst_addr_ok", 32'(inst_addr_ok), 32'd1);
    chk("f_sram_addr",    sram_addr, 32'h1c000000);
    chk("f_sram_we",      32'(sram_we), 32'd0);
    tick;
    inst_req = 1'b0;
    settle;
    chk("f_inst_data_ok", 32'(inst_data_ok), 32'd1);
    chk("f_inst_rdata",   inst_rdata, 32'h02800c21);
    chk("f_data_data_ok", 32'(data_data_ok), 32'd0);

    // simultaneous fetch and load
    tick;
    inst_req = 1'b1; inst_addr = 32'h1c000000;
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h1c000100;
    settle;
    chk("s_data_addr_ok", 32'(data_addr_ok), 32'd1);
    chk("s_inst_addr_ok0", 32'(inst_addr_ok), 32'd0);
    chk("s_sram_addr",    sram_addr, 32'h1c000100);
    tick;
    data_req = 1'b0;
    settle;
    chk("s_inst_addr_ok1", 32'(inst_addr_ok), 32'd1);
    chk("s_data_data_ok",  32'(data_data_ok), 32'd1);
    chk("s_data_rdata",    data_rdata, 32'hdeadbeef);
    chk("s_inst_data_ok1", 32'(inst_data_ok), 32'd0);
    tick;
    inst_req = 1'b0;
    settle;
    chk("s_inst_data_ok2", 32'(inst_data_ok), 32'd1);
    chk("s_inst_rdata",    inst_rdata, 32'h02800c21);
    chk("s_data_data_ok2", 32'(data_data_ok), 32'd0);

    // partial store then load of the same word
    tick;
    data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'b0011;
    data_addr = 32'h1c000200; data_wdata = 32'h12345678;
    settle;
    chk("st_addr_ok",    32'(data_addr_ok), 32'd1);
    chk("st_sram_we",    32'(sram_we), 32'b0011);
    chk("st_sram_wdata", sram_wdata, 32'h12345678);
    tick;
    data_wr = 1'b0;
    settle;
    chk("st_ack",        32'(data_data_ok), 32'd1);
    chk("st_ack_rdata",  data_rdata, 32'h0);
    chk("ld_addr_ok",    32'(data_addr_ok), 32'd1);
    chk("ld_sram_we",    32'(sram_we), 32'd0);
    tick;
    data_wr = 1'b1; data_wstrb = 4'b0000; data_wdata = 32'hffffffff;
    settle;
    chk("ld_data_ok",    32'(data_data_ok), 32'd1);
    chk("ld_rdata",      data_rdata, 32'haaaa5678);
    chk("z_sram_en",     32'(sram_en), 32'd1);
    chk("z_sram_we",     32'(sram_we), 32'd0);
    tick;
    data_req = 1'b0;
    settle;
    chk("z_ack",         32'(data_data_ok), 32'd1);
    chk("z_rdata",       data_rdata, 32'h0);

    // starvation guard: expected grants D,D,D,D,I,D,D,D,D,I
    tick;
    inst_req = 1'b1; inst_addr = 32'h1c000000;
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h1c000100;
    for (int i = 0; i < 10; i++) begin
      settle;
      chk($sformatf("sv_inst_ok%0d", i), 32'(inst_addr_ok), 32'(pat[i]));
      chk($sformatf("sv_data_ok%0d", i), 32'(data_addr_ok), 32'(!pat[i]));
      chk($sformatf("sv_cnt%0d", i), 32'(dut.r_starve_cnt), 32'(i % 5));
      if (i > 0) chk($sformatf("sv_inst_dok%0d", i), 32'(inst_data_ok), 32'(pat[i-1]));
      tick;
    end
    inst_req = 1'b0; data_req = 1'b0;
    settle;
    chk("sv_inst_dok_last", 32'(inst_data_ok), 32'd1);
    chk("sv_cnt_clear",     32'(dut.r_starve_cnt), 32'd0);

    // reset in the cycle after a load grant
    tick;
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h1c000100;
    settle;
    chk("rm_grant", 32'(data_addr_ok), 32'd1);
    tick;
    reset = 1'b1; inst_req = 1'b1;
    settle;
    chk("rm_dok_n1",     32'(data_data_ok), 32'd0);
    chk("rm_rdata_n1",   data_rdata, 32'h0);
    chk("rm_daddr_ok",   32'(data_addr_ok), 32'd0);
    chk("rm_iaddr_ok",   32'(inst_addr_ok), 32'd0);
    chk("rm_sram_en",    32'(sram_en), 32'd0);
    tick;
    reset = 1'b0; inst_req = 1'b0; data_req = 1'b0;
    settle;
    chk("rm_dok_n2",     32'(data_data_ok), 32'd0);
    chk("rm_iok_n2",     32'(inst_data_ok), 32'd0);
    chk("rm_cnt",        32'(dut.r_starve_cnt), 32'd0);

    // full-rate fetch streaming
    tick;
    inst_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      inst_addr = 32'h1c001000 + 32'(4*i);
      settle;
      chk($sformatf("st_iaok%0d", i), 32'(inst_addr_ok), 32'd1);
      if (i > 0) begin
        chk($sformatf("st_idok%0d", i), 32'(inst_data_ok), 32'd1);
        chk($sformatf("st_rd%0d", i), inst_rdata, 32'h5a000000 + 32'((i-1) * 17));
      end
      tick;
    end
    inst_req = 1'b0;
    settle;
    chk("st_idok8", 32'(inst_data_ok), 32'd1);
    chk("st_rd8",   inst_rdata, 32'h5a000000 + 32'(7 * 17));
    tick;
    settle;
    chk("st_idle",  32'(inst_data_ok), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares one synchronous single-port SRAM between the instruction-fetch requester and the load/store requester of the CPU core.
- Each requester gets an addr_ok/data_ok handshake.
- Grants at most one access per cycle: data port has fixed priority, with a starvation guard for fetch.
- Response is routed back to the granted requester one cycle later.
- Sits between the core's inst/data SRAM-style interfaces and a single physical RAM.

Parameters:
- STARVE_LIMIT, 4: consecutive denied fetch cycles after which fetch wins over data for one grant (legal 1..7).
- CNT_W, 3: width of the starvation counter. It must hold STARVE_LIMIT.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous reset, active-high
- inst_req  in  1  fetch request; held stable until inst_addr_ok
- inst_addr  in  32  fetch byte address
- inst_addr_ok  out  1  fetch request accepted this cycle
- inst_data_ok  out  1  fetch data valid this cycle
- inst_rdata  out  32  fetch data
- data_req  in  1  load/store request; held stable until data_addr_ok
- data_wr  in  1  1 = store, 0 = load
- data_wstrb  in  4  byte enables for store
- data_addr  in  32  load/store byte address
- data_wdata  in  32  store data
- data_addr_ok  out  1  data request accepted this cycle
- data_data_ok  out  1  load data valid / store complete this cycle
- data_rdata  out  32  load data
- sram_en  out  1  RAM access enable
- sram_we  out  4  RAM byte write enables
- sram_addr  out  32  RAM byte address
- sram_wdata  out  32  RAM write data
- sram_rdata  in  32  RAM read data, valid the cycle after sram_en

Behaviour:
Arbitration (combinational, same cycle):
- inst_force = (starve_cnt == STARVE_LIMIT).
- grant_data = data_req & ~(inst_req & inst_force).
- grant_inst = inst_req & ~grant_data.
- data_addr_ok = grant_data; inst_addr_ok = grant_inst. Never both high.

SRAM drive (combinational):
- sram_en = grant_data | grant_inst.
- On grant_data:
  - sram_addr = data_addr.
  - sram_we = data_wr ? data_wstrb : 4'b0.
  - sram_wdata = data_wdata.
- On grant_inst:
  - sram_addr = inst_addr.
  - sram_we = 0.
  - sram_wdata = 0.
- No grant: sram_en = 0, sram_we = 0, sram_addr = 0, sram_wdata = 0.

Response (registered, latency exactly 1 cycle after the grant):
- resp_owner register, 2 bits {inst, data}, captures {grant_inst, grant_data} every cycle.
- inst_data_ok = resp_owner.inst; data_data_ok = resp_owner.data.
- inst_rdata = sram_rdata when resp_owner.inst, else 0.
- data_rdata = sram_rdata when resp_owner.data and the registered access was a load, else 0.
- A store still produces data_data_ok one cycle after its grant, with data_rdata = 0.
- Back-to-back grants every cycle are allowed. Throughput is 1 access/cycle.

Starvation counter starve_cnt (CNT_W bits):
- Reset to 0.
- If inst_req & ~grant_inst: starve_cnt <= min(starve_cnt + 1, STARVE_LIMIT). It saturates and never wraps.
- If grant_inst, or ~inst_req: starve_cnt <= 0.

Reset:
- While reset = 1: resp_owner = 0, starve_cnt = 0. All *_addr_ok and sram_en are forced 0 regardless of requests.
- Reset out of reset (cycle after reset falls): inst_data_ok = 0, data_data_ok = 0, rdata outputs = 0.
- Reset asserted the cycle after a grant drops that pending response: no data_ok is ever issued for it.

Boundary conditions:
- Simultaneous requests with starve_cnt < STARVE_LIMIT: data wins, fetch waits.
- Simultaneous requests with starve_cnt == STARVE_LIMIT: fetch wins; data waits one cycle, then regains priority since the counter clears.
- data_wr = 1 with data_wstrb = 0: granted as an access with sram_en = 1 and sram_we = 0, and is acked.
- Requests are held by the requester; the arbiter stores no request state.

Test Plan:
- Fetch alone: inst_req = 1, inst_addr = 0x1c000000, RAM holds 0x02800c21 there -> inst_addr_ok = 1 and sram_addr = 0x1c000000 in cycle N; inst_data_ok = 1 and inst_rdata = 0x02800c21 in N+1; data_data_ok stays 0.
- Simultaneous: inst_req = 1 and data load at 0x1c000100 (RAM = 0xdeadbeef), cycle N -> data_addr_ok = 1 in N, inst_addr_ok = 1 in N+1; data_data_ok with 0xdeadbeef in N+1; inst_data_ok in N+2.
- Store, then load of the same address: store 0x12345678 with wstrb = 4'b0011 to 0x1c000200 (old value 0xaaaaaaaa), then a load -> sram_we = 4'b0011 on the store cycle; store acked next cycle with data_rdata = 0; load returns 0xaaaa5678.
- Starvation: data_req held high for 10 cycles with inst_req high throughout, STARVE_LIMIT = 4 -> pattern of grants is D,D,D,D,I,D,D,D,D,I; starve_cnt never exceeds 4.
- Reset mid-operation: grant a load in cycle N, assert reset in N+1 -> data_data_ok = 0 in N+1 and N+2; no addr_ok while reset = 1; counter reads 0 after release.
- Full-rate streaming: data_req idle, inst_req held with the address incrementing by 4 for 8 cycles -> inst_addr_ok high every cycle; inst_data_ok high for 8 consecutive cycles, each carrying the RAM word of the previous cycle's address.
